// File: rtl/word_tx_mux.sv
// Word-to-byte transmit multiplexer: takes one WORD_BYTES-wide word per handshake and
// feeds it MSB byte first to a byte UART transmitter, substituting ZERO_SUB for 0x00.
module word_tx_mux #(
    parameter int         WORD_BYTES     = 3,
    parameter logic [7:0] ZERO_SUB       = 8'h01,
    parameter int         GAP_CYCLES     = 0,
    parameter bit         SEND_ON_CHANGE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*WORD_BYTES-1:0] word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_done_tick,
    output logic                    busy,
    output logic                    zero_subst
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [W-1:0]  word_q, word_d;
    logic [W-1:0]  last_q, last_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          ready_q, ready_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          zsub_q, zsub_d;
    logic [7:0]    data_q, data_d;
    logic          load_byte;
    logic [7:0]    cur_byte;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        word_d    = word_q;
        last_d    = last_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        data_d    = data_q;
        start_d   = 1'b0;
        zsub_d    = 1'b0;
        load_byte = 1'b0;
        cur_byte  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (word_valid && ready_q) begin
                    shift_d = word_in;
                    word_d  = word_in;
                    idx_d   = '0;
                    if (!(SEND_ON_CHANGE && (word_in == last_q))) begin
                        state_d   = S_START;
                        load_byte = 1'b1;
                    end
                end
            end
            S_START: begin
                // A done tick coinciding with the start pulse belongs to the previous byte.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done_tick) begin
                    if (idx_q == LAST_IDX) begin
                        last_d  = word_q;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q << 8;
                        if (GAP_CYCLES > 0) begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end else begin
                            state_d   = S_START;
                            load_byte = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d   = S_START;
                    load_byte = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so tx_start lines up with START.
        if (load_byte) begin
            cur_byte = shift_d[W-1 -: 8];
            start_d  = 1'b1;
            zsub_d   = (cur_byte == 8'h00);
            data_d   = (cur_byte == 8'h00) ? ZERO_SUB : cur_byte;
        end

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            word_q  <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            zsub_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            zsub_q  <= zsub_d;
            data_q  <= data_d;
        end
    end

    assign word_ready = ready_q;
    assign tx_start   = start_q;
    assign busy       = busy_q;
    assign zero_subst = zsub_q;
    assign tx_data    = data_q;

endmodule
